// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-memory accesses, waits for the bus, formats loads, registers the writeback bundle.
// Optional MEM_MISALIGN_TRAP_EN adds out_misaligned and blocks misaligned accesses from the bus.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        stall,
  input  logic [31:0] result_alu,
  input  logic [31:0] store_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        MemToReg,
  input  logic        in_RegWrite,
  input  logic [4:0]  in_RegDest,
  input  logic        in_PCSrc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic        mem_done,
  output logic [31:0] data_mem,
  output logic [31:0] out_result_alu,
  output logic        out_MemToReg,
  output logic        out_RegWrite,
  output logic [4:0]  out_RegDest,
  output logic        out_PCSrc,
  output logic        mem_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        out_misaligned
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] tcnt;
  logic        is_load, is_store, mem_op, mis, accept_mem, timeout_hit;
  logic [31:0] wdata_f, rdata_f;
  logic [3:0]  wstrb_f;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic [31:0] lat_result;
  logic        lat_memtoreg, lat_regwrite, lat_pcsrc, lat_signed, lat_load;
  logic [4:0]  lat_regdest;
  logic [1:0]  lat_off, lat_size;

  assign is_load  = MemRead;
  assign is_store = MemWrite & ~MemRead;
  assign mem_op   = MemRead | MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = mem_op & (((MemSize == 2'b01) & result_alu[0]) |
                         (MemSize[1] & (result_alu[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign accept_mem  = (state == S_IDLE) & in_valid & mem_op & ~mis;
  assign stall       = (state == S_WAIT) | accept_mem;
  assign timeout_hit = (tcnt == TO_LAST);

  always_comb begin
    wdata_f = store_data;
    wstrb_f = 4'b1111;
    case (MemSize)
      2'b00: begin
        wdata_f = {4{store_data[7:0]}};
        wstrb_f = 4'b0001 << result_alu[1:0];
      end
      2'b01: begin
        wdata_f = {2{store_data[15:0]}};
        wstrb_f = result_alu[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!is_store) begin
      wdata_f = '0;
      wstrb_f = '0;
    end
  end

  always_comb begin
    byte_sel = mem_rdata[{lat_off, 3'b000} +: 8];
    half_sel = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_size)
      2'b00:   rdata_f = {{24{lat_signed & byte_sel[7]}}, byte_sel};
      2'b01:   rdata_f = {{16{lat_signed & half_sel[15]}}, half_sel};
      default: rdata_f = mem_rdata;
    endcase
    if (!lat_load) rdata_f = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_mem) state_nxt = S_WAIT;
      S_WAIT:  if (mem_ready || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt           <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      out_valid      <= 1'b0;
      mem_done       <= 1'b0;
      mem_err        <= 1'b0;
      data_mem       <= '0;
      out_result_alu <= '0;
      out_MemToReg   <= 1'b0;
      out_RegWrite   <= 1'b0;
      out_RegDest    <= '0;
      out_PCSrc      <= 1'b0;
      lat_result     <= '0;
      lat_memtoreg   <= 1'b0;
      lat_regwrite   <= 1'b0;
      lat_regdest    <= '0;
      lat_pcsrc      <= 1'b0;
      lat_off        <= '0;
      lat_size       <= '0;
      lat_signed     <= 1'b0;
      lat_load       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misaligned <= 1'b0;
`endif
    end else begin
      // Pulse-type outputs default low; bundle data fields hold between valids.
      out_valid    <= 1'b0;
      mem_done     <= 1'b0;
      mem_err      <= 1'b0;
      out_RegWrite <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misaligned <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept_mem) begin
            tcnt         <= '0;
            mem_req      <= 1'b1;
            mem_we       <= is_store;
            mem_addr     <= {result_alu[31:2], 2'b00};
            mem_wdata    <= wdata_f;
            mem_wstrb    <= wstrb_f;
            lat_result   <= result_alu;
            lat_memtoreg <= MemToReg;
            lat_regwrite <= in_RegWrite;
            lat_regdest  <= in_RegDest;
            lat_pcsrc    <= in_PCSrc;
            lat_off      <= result_alu[1:0];
            lat_size     <= MemSize;
            lat_signed   <= MemSigned;
            lat_load     <= is_load;
          end else if (in_valid) begin
            out_valid      <= 1'b1;
            data_mem       <= '0;
            out_result_alu <= result_alu;
            out_MemToReg   <= MemToReg;
            out_RegWrite   <= in_RegWrite & ~mis;
            out_RegDest    <= in_RegDest;
            out_PCSrc      <= in_PCSrc;
`ifdef MEM_MISALIGN_TRAP_EN
            out_misaligned <= mis;
`endif
          end
        end
        S_WAIT: begin
          if (mem_ready || timeout_hit) begin
            tcnt           <= '0;
            mem_req        <= 1'b0;
            out_valid      <= 1'b1;
            mem_done       <= mem_ready;
            mem_err        <= ~mem_ready;
            data_mem       <= mem_ready ? rdata_f : '0;
            out_result_alu <= lat_result;
            out_MemToReg   <= lat_memtoreg;
            out_RegWrite   <= lat_regwrite & mem_ready;
            out_RegDest    <= lat_regdest;
            out_PCSrc      <= lat_pcsrc;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: randomized loads/stores/ALU ops against a spec-level model, plus a bus responder.
module tb_memory_stage;

  localparam int TO = 4;

  logic        clk, rst, in_valid, stall;
  logic [31:0] result_alu, store_data;
  logic        MemRead, MemWrite, MemSigned, MemToReg, in_RegWrite, in_PCSrc;
  logic [1:0]  MemSize;
  logic [4:0]  in_RegDest;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        out_valid, mem_done, out_MemToReg, out_RegWrite, out_PCSrc, mem_err;
  logic [31:0] data_mem, out_result_alu;
  logic [4:0]  out_RegDest;

  memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .result_alu(result_alu), .store_data(store_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .MemToReg(MemToReg), .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest), .in_PCSrc(in_PCSrc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .mem_done(mem_done), .data_mem(data_mem),
    .out_result_alu(out_result_alu), .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite),
    .out_RegDest(out_RegDest), .out_PCSrc(out_PCSrc), .mem_err(mem_err)
  );

  typedef struct {
    logic [31:0] res;
    logic        m2r, rw, pc, done, err;
    logic [4:0]  rd;
    logic [31:0] dm;
    int          cyc;
  } exp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata, addr, wdata;
    logic        we;
    logic [3:0]  wstrb;
  } plan_t;

  exp_t  exp_q[$];
  plan_t bus_q[$];
  int    n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Bus responder: replies after the planned number of WAIT cycles, checks request stability.
  plan_t cur;
  bit    active = 0;
  int    k = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!active) begin
        active = 1;
        k = 0;
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unplanned: got request with no pending plan at cycle %0d", cyc);
          cur = '{delay: 1, rdata: 0, addr: mem_addr, wdata: mem_wdata, we: mem_we, wstrb: mem_wstrb};
        end else cur = bus_q.pop_front();
      end
      k++;
      chk("req_addr", mem_addr, cur.addr);
      chk("req_we", mem_we, cur.we);
      chk("req_wdata", mem_wdata, cur.wdata);
      chk("req_wstrb", mem_wstrb, cur.wstrb);
      mem_ready = (k == cur.delay);
      mem_rdata = (k == cur.delay) ? cur.rdata : $urandom;
    end else begin
      active = 0;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  // Monitor: pops one expectation per presented bundle.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) last_res = '0;
    else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: out_valid with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("out_result_alu", out_result_alu, e.res);
        chk("out_ctrl", {out_MemToReg, out_RegWrite, out_PCSrc, out_RegDest},
                        {e.m2r, e.rw, e.pc, e.rd});
        chk("mem_done", mem_done, e.done);
        chk("mem_err", mem_err, e.err);
        if (!e.err) chk("data_mem", data_mem, e.dm);
        last_res = e.res;
      end
    end else begin
      chk("idle_pulses", {mem_done, mem_err, out_RegWrite}, 0);
      chk("hold_result", out_result_alu, last_res);
    end
  end

  task automatic do_txn(input logic rd_, input logic wr_, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic rw, input logic [4:0] rdst,
                        input int delay, input logic [31:0] rdata);
    exp_t  x;
    plan_t p;
    int    sizeb, n_w, exp_w;
    logic [31:0] v;
    logic  m2r, pc;
    m2r = 1'($urandom); pc = 1'($urandom);
    x = '{res: a, m2r: m2r, rw: rw, pc: pc, done: 0, err: 0, rd: rdst, dm: 0, cyc: cyc + 1};
    exp_w = 0;
    if (rd_ || wr_) begin
      sizeb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      p.delay = delay; p.rdata = rdata; p.addr = a & ~32'd3; p.we = wr_ && !rd_;
      p.wstrb = 0; p.wdata = 0;
      if (p.we) begin
        if (sizeb == 1)      begin p.wstrb = 4'(1 << (a % 4)); p.wdata = (d & 32'hFF) * 32'h01010101; end
        else if (sizeb == 2) begin p.wstrb = (a & 2) ? 4'hC : 4'h3; p.wdata = (d & 32'hFFFF) * 32'h00010001; end
        else                 begin p.wstrb = 4'hF; p.wdata = d; end
      end
      if (delay <= TO) begin
        x.done = 1; x.cyc = cyc + 1 + delay; exp_w = delay;
        if (rd_) begin
          if (sizeb == 4) v = rdata;
          else if (sizeb == 2) begin
            v = (a & 2) ? (rdata >> 16) : (rdata & 32'hFFFF);
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
          end else begin
            v = (rdata >> (8 * (a % 4))) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
          end
          x.dm = v;
        end
      end else begin
        x.err = 1; x.rw = 0; x.cyc = cyc + 1 + TO; exp_w = TO;
      end
      bus_q.push_back(p);
    end
    exp_q.push_back(x);
    in_valid = 1; result_alu = a; store_data = d; MemRead = rd_; MemWrite = wr_;
    MemSize = sz; MemSigned = sg; MemToReg = m2r; in_RegWrite = rw; in_RegDest = rdst; in_PCSrc = pc;
    #1 chk("stall_accept", stall, rd_ || wr_);
    @(posedge clk); #1;
    in_valid = 0; result_alu = $urandom; store_data = $urandom;
    MemRead = 1'($urandom); MemWrite = 1'($urandom);
    n_w = 0;
    for (int i = 0; i < 20 && stall; i++) begin
      n_w++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", n_w, exp_w);
  endtask

  task automatic rand_txn();
    int kind;
    kind = $urandom_range(0, 2);
    do_txn(kind == 1 || (kind == 2 && $urandom_range(0, 3) == 0), kind == 2,
           2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom),
           $urandom_range(1, 6), $urandom);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 0; in_valid = 0; result_alu = 0; store_data = 0; MemRead = 0; MemWrite = 0;
    MemSize = 0; MemSigned = 0; MemToReg = 0; in_RegWrite = 0; in_RegDest = 0; in_PCSrc = 0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {mem_req, mem_we, out_valid, mem_done, mem_err, out_MemToReg, out_RegWrite, out_PCSrc, stall}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb_rd", {mem_wstrb, out_RegDest}, 0);
    chk("rst_data", data_mem | out_result_alu, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;

    do_txn(0, 0, 2'b10, 0, 32'h1234, 0, 1, 5'd5, 1, 0);                    // ALU op
    do_txn(1, 0, 2'b00, 1, 32'h103, 0, 1, 5'd7, 3, 32'h80FFFFFF);          // LB signed
    do_txn(0, 1, 2'b01, 0, 32'h102, 32'hDEADBEEF, 0, 5'd0, 2, 0);          // SH
    do_txn(1, 0, 2'b10, 0, 32'h200, 0, 1, 5'd9, 99, 32'h12345678);         // LW timeout
    do_txn(1, 0, 2'b01, 0, 32'h302, 0, 1, 5'd3, TO, 32'h8001_7FFE);        // ready on last cycle
    do_txn(1, 1, 2'b11, 0, 32'h407, 0, 1, 5'd4, 1, 32'hCAFEF00D);          // read+write = load
    do_txn(0, 1, 2'b00, 0, 32'h501, 32'h000000A5, 0, 5'd1, 5, 0);         // store timeout
    for (int i = 0; i < 250; i++) rand_txn();
    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", exp_q.size(), 0);

    // Reset during an outstanding access.
    bus_q.push_back('{delay: 99, rdata: 0, addr: 32'h600, wdata: 0, we: 0, wstrb: 0});
    in_valid = 1; MemRead = 1; MemWrite = 0; MemSize = 2'b10; result_alu = 32'h600;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 chk("wait_req", mem_req, 1);
    #2 rst = 0;
    #1 chk("async_req_drop", mem_req, 0);
    exp_q.delete(); bus_q.delete();
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("post_rst_flags", {mem_req, mem_we, out_valid, mem_done, mem_err, out_RegWrite, stall}, 0);
    chk("post_rst_data", mem_addr | mem_wdata | data_mem | out_result_alu, 0);
    chk("post_rst_wstrb", mem_wstrb, 0);
    do_txn(0, 0, 2'b00, 0, 32'hABCD, 0, 1, 5'd2, 1, 0);
    repeat (2) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
